// File: rtl/tft43_pkg.sv
// Shared constants for the TFT43 frame buffer and the scan-out reader FSM encoding.
package tft43_pkg;

  localparam int H_ACTIVE_DEF = 480;
  localparam int V_ACTIVE_DEF = 272;
  localparam int RGB_W        = 16;
  localparam int SDRAM_AW     = 24;
  localparam int BURST_LEN    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REQ,
    ST_PUSH,
    ST_FETCHED
  } readerState_t;

  // Word address of a burst; wraps naturally at 24 bits.
  function automatic logic [SDRAM_AW-1:0] burstAddr(input logic [SDRAM_AW-1:0] base,
                                                    input logic [SDRAM_AW-1:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Single-clock pixel FIFO with synchronous flush, registered occupancy count and full/empty flags.
module pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  output logic [WIDTH-1:0]           headData,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign doPop    = pop && !empty && !flush;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still safe then.
  assign doPush   = push && !flush && (!full || doPop);
  assign headData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end

endmodule

// File: rtl/sdram_frame_reader.sv
// Frame-buffer scan-out: walks the frame in 4-word SDRAM bursts and feeds one RGB565
// pixel per timing-generator request from a small FIFO.
module sdram_frame_reader
  import tft43_pkg::*;
#(
  parameter int                  H_ACTIVE        = H_ACTIVE_DEF,
  parameter int                  V_ACTIVE        = V_ACTIVE_DEF,
  parameter logic [SDRAM_AW-1:0] FB_BASE         = 24'h000000,
  parameter int                  FIFO_DEPTH      = 16,
  parameter logic [RGB_W-1:0]    UNDERFLOW_COLOR = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                iFrame_Start,
  input  logic                iPixel_Req,
  output logic [RGB_W-1:0]    oPixel_Data,
  output logic                oPixel_Valid,
  output logic                oUnderflow,
  output logic                oFrame_Done,
  output logic [SDRAM_AW-1:0] oSDRAM_Rd_Addr,
  output logic                oSDRAM_Rd_Req,
  input  logic                iSDRAM_Rd_Done,
  input  logic [RGB_W-1:0]    iSDRAM_Rd_Data1,
  input  logic [RGB_W-1:0]    iSDRAM_Rd_Data2,
  input  logic [RGB_W-1:0]    iSDRAM_Rd_Data3,
  input  logic [RGB_W-1:0]    iSDRAM_Rd_Data4
);

  localparam int TOTAL_PIX    = H_ACTIVE * V_ACTIVE;
  localparam int TOTAL_BURSTS = TOTAL_PIX / BURST_LEN;
  // +1 so the counters can hold the terminal count itself.
  localparam int PIX_W        = $clog2(TOTAL_PIX + 1);
  localparam int BIDX_W       = $clog2(TOTAL_BURSTS + 1);
  localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1;
  localparam int PIDX_W       = $clog2(BURST_LEN);

  readerState_t        state;
  readerState_t        stateNext;
  logic [BIDX_W-1:0]   burstIdx;
  logic [PIDX_W-1:0]   pushIdx;
  logic                discard;
  logic [RGB_W-1:0]    burstWords [BURST_LEN];
  logic [RGB_W-1:0]    rdWords    [BURST_LEN];
  logic [SDRAM_AW-1:0] addrReg;
  logic [PIX_W-1:0]    pixelCnt;

  logic [RGB_W-1:0]    fifoHead;
  logic [CNT_W-1:0]    fifoCount;
  logic                fifoFull;
  logic                fifoEmpty;
  logic                fifoPush;
  logic                fifoPop;
  logic                freeOk;
  logic                burstAccepted;

  assign rdWords[0] = iSDRAM_Rd_Data1;
  assign rdWords[1] = iSDRAM_Rd_Data2;
  assign rdWords[2] = iSDRAM_Rd_Data3;
  assign rdWords[3] = iSDRAM_Rd_Data4;

  assign freeOk        = (fifoCount <= CNT_W'(FIFO_DEPTH - BURST_LEN));
  assign burstAccepted = (state == ST_REQ) && iSDRAM_Rd_Done;
  assign fifoPush      = (state == ST_PUSH) && !iFrame_Start && !fifoFull;
  assign fifoPop       = iPixel_Req && !iFrame_Start && !fifoEmpty;

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:    if (iFrame_Start) stateNext = ST_CHECK;
      ST_CHECK: begin
        if (iFrame_Start)                                 stateNext = ST_CHECK;
        else if (burstIdx == BIDX_W'(TOTAL_BURSTS))      stateNext = ST_FETCHED;
        else if (en && freeOk)                           stateNext = ST_REQ;
      end
      ST_REQ: begin
        if (iSDRAM_Rd_Done) stateNext = (discard || iFrame_Start) ? ST_CHECK : ST_PUSH;
      end
      ST_PUSH: begin
        if (iFrame_Start || pushIdx == PIDX_W'(BURST_LEN - 1)) stateNext = ST_CHECK;
      end
      ST_FETCHED: if (iFrame_Start) stateNext = ST_CHECK;
      default:    stateNext = ST_IDLE;
    endcase
  end

  assign oSDRAM_Rd_Req  = (state == ST_REQ);
  assign oSDRAM_Rd_Addr = addrReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      burstIdx <= '0;
      pushIdx  <= '0;
      discard  <= 1'b0;
      addrReg  <= '0;
      for (int i = 0; i < BURST_LEN; i++) burstWords[i] <= '0;
    end else begin
      state <= stateNext;

      if (iFrame_Start)                 burstIdx <= '0;
      else if (burstAccepted && !discard) burstIdx <= burstIdx + 1'b1;

      pushIdx <= (state == ST_PUSH) ? pushIdx + 1'b1 : '0;

      // A restart during an open request must still complete the handshake, then drop the data.
      if (iFrame_Start && state == ST_REQ && !iSDRAM_Rd_Done) discard <= 1'b1;
      else if (state != ST_REQ || iSDRAM_Rd_Done)          discard <= 1'b0;

      if (state == ST_CHECK && stateNext == ST_REQ) begin
        addrReg <= burstAddr(FB_BASE, SDRAM_AW'(burstIdx));
      end

      if (burstAccepted) begin
        for (int i = 0; i < BURST_LEN; i++) burstWords[i] <= rdWords[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oPixel_Data  <= '0;
      oPixel_Valid <= 1'b0;
      oUnderflow   <= 1'b0;
      oFrame_Done  <= 1'b0;
      pixelCnt     <= '0;
    end else begin
      oPixel_Valid <= iPixel_Req;
      oFrame_Done  <= iPixel_Req && !iFrame_Start && (pixelCnt == PIX_W'(TOTAL_PIX - 1));
      if (iPixel_Req) begin
        oPixel_Data <= (iFrame_Start || fifoEmpty) ? UNDERFLOW_COLOR : fifoHead;
      end

      if (iFrame_Start)                 oUnderflow <= 1'b0;
      else if (iPixel_Req && fifoEmpty) oUnderflow <= 1'b1;

      if (iFrame_Start) pixelCnt <= '0;
      else if (iPixel_Req && pixelCnt != PIX_W'(TOTAL_PIX)) pixelCnt <= pixelCnt + 1'b1;
    end
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RGB_W)
  ) uFifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (iFrame_Start),
    .push     (fifoPush),
    .pushData (burstWords[pushIdx]),
    .pop      (fifoPop),
    .headData (fifoHead),
    .count    (fifoCount),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Scoreboard bench for sdram_frame_reader on an 8x4 frame: an SDRAM responder model checks
// burst addresses, and a pixel monitor pops expected pixels whenever oPixel_Valid is seen.
module tb_sdram_frame_reader;

  localparam int          TOTAL = 32;
  localparam logic [15:0] UF    = 16'hDEAD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        iFrame_Start = 1'b0;
  logic        iPixel_Req = 1'b0;
  logic [15:0] oPixel_Data;
  logic        oPixel_Valid;
  logic        oUnderflow;
  logic        oFrame_Done;
  logic [23:0] oSDRAM_Rd_Addr;
  logic        oSDRAM_Rd_Req;
  logic        iSDRAM_Rd_Done = 1'b0;
  logic [15:0] iSDRAM_Rd_Data1 = '0;
  logic [15:0] iSDRAM_Rd_Data2 = '0;
  logic [15:0] iSDRAM_Rd_Data3 = '0;
  logic [15:0] iSDRAM_Rd_Data4 = '0;

  sdram_frame_reader #(
    .H_ACTIVE        (8),
    .V_ACTIVE        (4),
    .FB_BASE         (24'h000000),
    .FIFO_DEPTH      (16),
    .UNDERFLOW_COLOR (UF)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .iFrame_Start    (iFrame_Start),
    .iPixel_Req      (iPixel_Req),
    .oPixel_Data     (oPixel_Data),
    .oPixel_Valid    (oPixel_Valid),
    .oUnderflow      (oUnderflow),
    .oFrame_Done     (oFrame_Done),
    .oSDRAM_Rd_Addr  (oSDRAM_Rd_Addr),
    .oSDRAM_Rd_Req   (oSDRAM_Rd_Req),
    .iSDRAM_Rd_Done  (iSDRAM_Rd_Done),
    .iSDRAM_Rd_Data1 (iSDRAM_Rd_Data1),
    .iSDRAM_Rd_Data2 (iSDRAM_Rd_Data2),
    .iSDRAM_Rd_Data3 (iSDRAM_Rd_Data3),
    .iSDRAM_Rd_Data4 (iSDRAM_Rd_Data4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        done;
    logic        uflow;
  } pixExp_t;

  pixExp_t     pixQ[$];
  logic [23:0] addrQ[$];
  int          errors = 0;
  int          checks = 0;
  int          lat = 2;
  int          reqCount = 0;
  logic        reqLast = 1'b0;
  int          waitCnt = 0;
  logic        busy = 1'b0;
  logic [23:0] curAddr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] burstWord(input logic [23:0] addr, input int k);
    return 16'(16'h1111 * (k + 1)) ^ {addr[7:0], 8'h00};
  endfunction

  function automatic logic [15:0] expPix(input int idx);
    logic [7:0] a;
    a = 8'(4 * (idx / 4));
    return 16'(16'h1111 * (idx % 4 + 1)) ^ {a, 8'h00};
  endfunction

  // SDRAM read-port responder
  initial begin : sdramModel
    forever begin
      @(negedge clk);
      iSDRAM_Rd_Done = 1'b0;
      if (rst) begin
        busy = 1'b0;
      end else if (!busy) begin
        if (oSDRAM_Rd_Req) begin
          busy    = 1'b1;
          curAddr = oSDRAM_Rd_Addr;
          waitCnt = lat;
          reqCount++;
          if (addrQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL req_unexpected: got addr %h want no request", curAddr);
          end else begin
            check("req_addr", 32'(curAddr), 32'(addrQ.pop_front()));
          end
        end
      end else begin
        check("req_held", 32'(oSDRAM_Rd_Req), 32'd1);
        if (!oSDRAM_Rd_Req) begin
          busy = 1'b0;
        end else if (waitCnt == 0) begin
          iSDRAM_Rd_Done  = 1'b1;
          iSDRAM_Rd_Data1 = burstWord(curAddr, 0);
          iSDRAM_Rd_Data2 = burstWord(curAddr, 1);
          iSDRAM_Rd_Data3 = burstWord(curAddr, 2);
          iSDRAM_Rd_Data4 = burstWord(curAddr, 3);
          busy = 1'b0;
        end else begin
          waitCnt--;
        end
      end
    end
  end

  always @(posedge clk) reqLast <= iPixel_Req;

  // Pixel monitor: compares every presented pixel against the scoreboard head
  initial begin : pixMonitor
    pixExp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (oPixel_Valid || reqLast)) begin
        check("valid_latency", 32'(oPixel_Valid), 32'(reqLast));
        if (oPixel_Valid) begin
          if (pixQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pix_unexpected: got data %h want no pixel", oPixel_Data);
          end else begin
            e = pixQ.pop_front();
            check("pix_data", 32'(oPixel_Data), 32'(e.data));
            check("frame_done", 32'(oFrame_Done), 32'(e.done));
            check("underflow", 32'(oUnderflow), 32'(e.uflow));
            $display("pixel data=%h done=%0b uflow=%0b", oPixel_Data, oFrame_Done, oUnderflow);
          end
        end
      end
      if (!rst && oFrame_Done && !oPixel_Valid) check("done_idle", 32'(oFrame_Done), 32'd0);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frameStart();
    iFrame_Start = 1'b1;
    tick();
    iFrame_Start = 1'b0;
  endtask

  task automatic popPixels(input int first, input int n);
    pixExp_t e;
    for (int i = 0; i < n; i++) begin
      e.data  = expPix(first + i);
      e.done  = (first + i == TOTAL - 1);
      e.uflow = 1'b0;
      pixQ.push_back(e);
      iPixel_Req = 1'b1;
      tick();
    end
    iPixel_Req = 1'b0;
  endtask

  task automatic waitReq(input logic [23:0] addr);
    int n;
    n = 0;
    while (!(oSDRAM_Rd_Req && oSDRAM_Rd_Addr == addr) && n < 200) begin
      tick();
      n++;
    end
    check("wait_req", 32'(oSDRAM_Rd_Req && oSDRAM_Rd_Addr == addr), 32'd1);
  endtask

  initial begin : stimulus
    pixExp_t e;
    int      rc;

    // Reset state
    tick();
    tick();
    check("rst_req", 32'(oSDRAM_Rd_Req), 32'd0);
    check("rst_addr", 32'(oSDRAM_Rd_Addr), 32'd0);
    check("rst_valid", 32'(oPixel_Valid), 32'd0);
    check("rst_data", 32'(oPixel_Data), 32'd0);
    check("rst_uflow", 32'(oUnderflow), 32'd0);
    check("rst_done", 32'(oFrame_Done), 32'd0);
    rst = 1'b0;
    en  = 1'b1;

    // Reset asserted in the middle of an open request
    lat = 10;
    addrQ.push_back(24'h0);
    frameStart();
    waitReq(24'h0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_req", 32'(oSDRAM_Rd_Req), 32'd0);
    check("midrst_addr", 32'(oSDRAM_Rd_Addr), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    rc = reqCount;
    repeat (20) tick();
    check("idle_after_rst", 32'(reqCount - rc), 32'd0);

    // Fill limit, with en gating checked first
    lat = 2;
    en  = 1'b0;
    addrQ.push_back(24'd0);
    addrQ.push_back(24'd4);
    addrQ.push_back(24'd8);
    addrQ.push_back(24'd12);
    frameStart();
    rc = reqCount;
    repeat (10) tick();
    check("en_gate", 32'(reqCount - rc), 32'd0);
    en = 1'b1;
    repeat (80) tick();
    check("fill_bursts", 32'(reqCount - rc), 32'd4);
    check("fill_addrq", 32'(addrQ.size()), 32'd0);
    check("fill_req_low", 32'(oSDRAM_Rd_Req), 32'd0);

    // Drain with refills, then the rest of the frame
    addrQ.push_back(24'd16);
    addrQ.push_back(24'd20);
    addrQ.push_back(24'd24);
    addrQ.push_back(24'd28);
    popPixels(0, 16);
    repeat (80) tick();
    check("refill_addrq", 32'(addrQ.size()), 32'd0);
    popPixels(16, 16);
    repeat (5) tick();
    check("pre_uflow", 32'(oUnderflow), 32'd0);

    // Underflow beyond the frame
    for (int i = 0; i < 2; i++) begin
      e = '{UF, 1'b0, 1'b1};
      pixQ.push_back(e);
      iPixel_Req = 1'b1;
      tick();
    end
    iPixel_Req = 1'b0;
    repeat (3) tick();
    check("uflow_sticky", 32'(oUnderflow), 32'd1);

    // Restart with a same-cycle pixel request, then restart again during the addr-8 request
    lat = 10;
    addrQ.push_back(24'd0);
    addrQ.push_back(24'd4);
    addrQ.push_back(24'd8);
    e = '{UF, 1'b0, 1'b0};
    pixQ.push_back(e);
    iPixel_Req   = 1'b1;
    iFrame_Start = 1'b1;
    tick();
    iPixel_Req   = 1'b0;
    iFrame_Start = 1'b0;
    tick();
    check("uflow_cleared", 32'(oUnderflow), 32'd0);
    waitReq(24'd8);
    frameStart();
    lat = 2;
    addrQ.push_back(24'd0);
    addrQ.push_back(24'd4);
    addrQ.push_back(24'd8);
    addrQ.push_back(24'd12);
    repeat (100) tick();
    check("restart_addrq", 32'(addrQ.size()), 32'd0);
    addrQ.push_back(24'd16);
    addrQ.push_back(24'd20);
    addrQ.push_back(24'd24);
    addrQ.push_back(24'd28);
    popPixels(0, 16);
    repeat (80) tick();
    popPixels(16, 16);
    repeat (5) tick();

    check("end_pixq", 32'(pixQ.size()), 32'd0);
    check("end_addrq", 32'(addrQ.size()), 32'd0);
    check("end_uflow", 32'(oUnderflow), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_frame_reader.md
Name: sdram_frame_reader

Overview:
- Scan-out side of the TFT43 frame buffer; the read counterpart to the draw path that writes 4-pixel bursts into SDRAM.
- Walks the active frame linearly and issues 4-word SDRAM burst reads.
- Buffers the returned RGB565 pixels in a small FIFO and hands one pixel per request to the TFT timing generator.
- Sits between the SDRAM controller read port and the LCD timing/output stage.

Parameters:
- H_ACTIVE, 480: active pixels per line.
- V_ACTIVE, 272: active lines per frame.
- FB_BASE, 24'h000000: SDRAM word address of pixel (0,0).
- FIFO_DEPTH, 16: pixel FIFO depth in words; power of 2, at least 8.
- UNDERFLOW_COLOR, 16'h0000: pixel output when the FIFO is empty.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  enables new SDRAM requests.
- iFrame_Start  in  1  1-cycle pulse at the start of vertical blanking; restarts the frame.
- iPixel_Req  in  1  timing generator requests the next active pixel.
- oPixel_Data  out  16  RGB565 pixel.
- oPixel_Valid  out  1  1-cycle strobe qualifying oPixel_Data.
- oUnderflow  out  1  sticky flag: a request hit an empty FIFO.
- oFrame_Done  out  1  1-cycle pulse when the last pixel of the frame is popped.
- oSDRAM_Rd_Addr  out  24  Bank(2)+Row(13)+Column(9) burst start address.
- oSDRAM_Rd_Req  out  1  read request.
- iSDRAM_Rd_Done  in  1  1-cycle pulse; Data1..4 are valid in the same cycle.
- iSDRAM_Rd_Data1..iSDRAM_Rd_Data4  in  16 each  burst words in pixel order.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; FIFO empty; burst and pixel counters 0.
- FSM states and transitions:
  - IDLE: on iFrame_Start go to CHECK.
  - CHECK: if burst_idx == H_ACTIVE*V_ACTIVE/4, go to FETCHED. Else, if en=1 and FIFO free slots >= 4, go to REQ.
  - REQ: oSDRAM_Rd_Addr = FB_BASE + 4*burst_idx (24-bit wrap). Hold oSDRAM_Rd_Req=1 until iSDRAM_Rd_Done is sampled high. On Done: latch Data1..4, drop Req next cycle, increment burst_idx, go to PUSH.
  - PUSH: write one latched word per cycle, Data1 first; after 4 cycles go to CHECK.
  - FETCHED: wait for iFrame_Start, then go to CHECK.
- Request rules: never more than one request outstanding. Req never drops before Done, including when iFrame_Start arrives or en falls.
- en=0: no new request leaves CHECK. An in-flight REQ/PUSH completes. Pixel pops continue.
- Pixel path:
  - iPixel_Req in cycle N gives oPixel_Valid=1 in cycle N+1.
  - oPixel_Data = FIFO head, or UNDERFLOW_COLOR if the FIFO is empty.
  - oPixel_Data holds its last value when Valid=0.
- Underflow: a request with an empty FIFO sets oUnderflow, which stays 1 until the next iFrame_Start. The pixel counter still increments.
- Push and pop in the same cycle are allowed; occupancy is unchanged. The free-slot check uses registered occupancy, so the FIFO never overflows.
- oFrame_Done: pulses in the cycle after the pop that brings the pixel count to H_ACTIVE*V_ACTIVE. Extra requests beyond that count return UNDERFLOW_COLOR and set oUnderflow.
- iFrame_Start:
  - Flushes the FIFO, clears both counters and oUnderflow, and restarts at FB_BASE.
  - If it arrives during REQ, latch a discard flag: finish the handshake, drop the data, skip PUSH, go to CHECK with burst_idx=0.
  - If it arrives during PUSH, abort the remaining pushes.
  - iFrame_Start and iPixel_Req in the same cycle: the flush wins and the request returns UNDERFLOW_COLOR without setting oUnderflow.
- Width rules: burst_idx and pixel count are sized by $clog2 of the frame size. Occupancy is $clog2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared package (tft43_pkg): H_ACTIVE/V_ACTIVE defaults, RGB565 width, SDRAM address width 24, burst length 4, reader FSM state encoding.
- One sub-module: pixel_fifo, a synchronous single-clock FIFO with flush input, push/pop, registered count, and full/empty flags.

Test Plan:
- Reset: assert rst mid-REQ -> all outputs 0 immediately, FSM IDLE, no Req after release until iFrame_Start.
- Fill limit: iFrame_Start, no pixel requests, Done returns 16'h1111..16'h4444 each burst -> Req addresses 0,4,8,12, then Req stays 0 with the FIFO at 16/16.
- Ordering and latency: after fill, continuous iPixel_Req -> Valid one cycle after each request, data 1111,2222,3333,4444 repeating, refill request issued when free slots reach 4.
- Underflow: iPixel_Req with the FIFO empty -> oPixel_Data=UNDERFLOW_COLOR, oUnderflow=1 held until the next iFrame_Start.
- Restart mid-burst: iFrame_Start while Req=1 with address 8 -> Req held until Done, data discarded, FIFO empty, next Req address FB_BASE.
- Small frame (H_ACTIVE=8, V_ACTIVE=2): 4 bursts at addresses 0,4,8,12, then FETCHED; oFrame_Done pulses once, after the 16th pop.
